// File: rtl/uart_mmio_responder.sv
// Memory-mapped 8N1 UART (TX + RX with status flags) on the core data bus, 16-byte window at BASE_ADDR.
// Latency: reads are combinational from HADDR (zero cycles); writes take effect on the next clock edge.
// Backpressure: none on the bus; a TX write while a frame is in flight is dropped and flagged (drop).
//
// Ports:
//   clock, reset       system clock (rising edge), asynchronous active-low reset
//   HADDR, HWDATA      byte address and write data from the core
//   MemWrite           core write enable; a multi-cycle assertion counts as one write
//   HRDATA_UART, hit   read data (0 outside the window) and window-hit select for the top-level mux
//   uart_tx, uart_rx   serial out (registered, idle high) and serial in (asynchronous)
//
// Register map (HADDR[3:2]):
//   0x0 TX_DATA    W: [7:0] byte to send          R: last accepted byte
//   0x4 TX_STATUS  R: bit0 busy, bit1 drop        W1C: bit1
//   0x8 RX_DATA    R: [7:0] last received byte    W: ignored
//   0xC RX_STATUS  R: bit0 valid, bit1 overrun, bit2 frame_err   W1C: bits 2:0

module uart_mmio_responder #(
   parameter int                LENGTH       = 32,
   parameter logic [LENGTH-1:0] BASE_ADDR    = 'h1001_0000,
   parameter int                CLKS_PER_BIT = 434
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [LENGTH-1:0] HADDR,
   input  logic [LENGTH-1:0] HWDATA,
   input  logic              MemWrite,
   output logic [LENGTH-1:0] HRDATA_UART,
   output logic              hit,
   output logic              uart_tx,
   input  logic              uart_rx
);

   localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);

   localparam logic [1:0] REG_TX_DATA   = 2'd0;
   localparam logic [1:0] REG_TX_STATUS = 2'd1;
   localparam logic [1:0] REG_RX_DATA   = 2'd2;
   localparam logic [1:0] REG_RX_STATUS = 2'd3;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   // ------------------------------------------------------------------
   // Bus decode and write strobe
   // ------------------------------------------------------------------
   logic [1:0] sel;
   logic       wr_q;
   logic       wr;
   logic       wr_tx_data;
   logic       wr_tx_stat;
   logic       wr_rx_stat;
   logic       clr_drop;
   logic       clr_valid;
   logic       clr_overrun;
   logic       clr_frame_err;

   assign hit = (HADDR[LENGTH-1:4] == BASE_ADDR[LENGTH-1:4]);
   assign sel = HADDR[3:2];

   // The core may hold MemWrite for several cycles of one store; only the
   // first cycle of a contiguous in-window write is acted upon.
   assign wr = MemWrite & hit & ~wr_q;

   assign wr_tx_data    = wr & (sel == REG_TX_DATA);
   assign wr_tx_stat    = wr & (sel == REG_TX_STATUS);
   assign wr_rx_stat    = wr & (sel == REG_RX_STATUS);
   assign clr_drop      = wr_tx_stat & HWDATA[1];
   assign clr_valid     = wr_rx_stat & HWDATA[0];
   assign clr_overrun   = wr_rx_stat & HWDATA[1];
   assign clr_frame_err = wr_rx_stat & HWDATA[2];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_q <= 1'b0;
      end else begin
         wr_q <= MemWrite & hit;
      end
   end

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   tx_state_t     tx_state;
   tx_state_t     tx_state_nx;
   logic [CW-1:0] tx_cnt;
   logic [CW-1:0] tx_cnt_nx;
   logic [2:0]    tx_idx;
   logic [2:0]    tx_idx_nx;
   logic [7:0]    tx_byte;
   logic          tx_drop;
   logic          tx_busy;
   logic          tx_accept;
   logic          tx_line_nx;

   assign tx_busy   = (tx_state != TX_IDLE);
   assign tx_accept = wr_tx_data & ~tx_busy;

   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      tx_idx_nx   = tx_idx;
      tx_line_nx  = 1'b1;
      case (tx_state)
         TX_IDLE: begin
            if (tx_accept) begin
               tx_state_nx = TX_START;
               tx_cnt_nx   = '0;
            end
         end
         TX_START: begin
            if (tx_cnt == BIT_LAST) begin
               tx_state_nx = TX_DATA;
               tx_cnt_nx   = '0;
               tx_idx_nx   = '0;
            end else begin
               tx_cnt_nx = tx_cnt + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_nx = '0;
               if (tx_idx == 3'd7) begin
                  tx_state_nx = TX_STOP;
               end else begin
                  tx_idx_nx = tx_idx + 1'b1;
               end
            end else begin
               tx_cnt_nx = tx_cnt + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt == BIT_LAST) begin
               tx_state_nx = TX_IDLE;
               tx_cnt_nx   = '0;
            end else begin
               tx_cnt_nx = tx_cnt + 1'b1;
            end
         end
         default: begin
            tx_state_nx = TX_IDLE;
            tx_cnt_nx   = '0;
            tx_idx_nx   = '0;
         end
      endcase

      // The line level is derived from the state being entered so that the
      // registered uart_tx changes on the same edge as the state register.
      // On entry to START the byte is latched on that same edge, but the
      // start bit does not depend on it.
      case (tx_state_nx)
         TX_START: tx_line_nx = 1'b0;
         TX_DATA:  tx_line_nx = tx_byte[tx_idx_nx];
         default:  tx_line_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_byte  <= '0;
         tx_drop  <= 1'b0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_idx   <= tx_idx_nx;
         uart_tx  <= tx_line_nx;
         if (tx_accept) begin
            tx_byte <= HWDATA[7:0];
         end
         // A set in the same cycle as the W1C takes priority.
         tx_drop <= (tx_drop & ~clr_drop) | (wr_tx_data & tx_busy);
      end
   end

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   logic          rx_meta;
   logic          rx_sync;
   logic          rx_prev;
   rx_state_t     rx_state;
   rx_state_t     rx_state_nx;
   logic [CW-1:0] rx_cnt;
   logic [CW-1:0] rx_cnt_nx;
   logic [2:0]    rx_idx;
   logic [2:0]    rx_idx_nx;
   logic [7:0]    rx_shift;
   logic [7:0]    rx_shift_nx;
   logic [7:0]    rx_data;
   logic          rx_done;
   logic          rx_ferr_set;
   logic          rx_valid;
   logic          rx_overrun;
   logic          rx_frame_err;

   always_comb begin
      rx_state_nx = rx_state;
      rx_cnt_nx   = rx_cnt;
      rx_idx_nx   = rx_idx;
      rx_shift_nx = rx_shift;
      rx_done     = 1'b0;
      rx_ferr_set = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_prev & ~rx_sync) begin
               rx_state_nx = RX_START;
               rx_cnt_nx   = '0;
            end
         end
         RX_START: begin
            // Mid-start-bit check rejects short low glitches; from here on
            // every sample lands near the centre of its bit.
            if (rx_cnt == HALF_BIT) begin
               rx_cnt_nx = '0;
               rx_idx_nx = '0;
               if (rx_sync) begin
                  rx_state_nx = RX_IDLE;
               end else begin
                  rx_state_nx = RX_DATA;
               end
            end else begin
               rx_cnt_nx = rx_cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nx   = '0;
               rx_shift_nx = {rx_sync, rx_shift[7:1]};
               if (rx_idx == 3'd7) begin
                  rx_state_nx = RX_STOP;
               end else begin
                  rx_idx_nx = rx_idx + 1'b1;
               end
            end else begin
               rx_cnt_nx = rx_cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nx = '0;
               if (rx_sync) begin
                  rx_done     = 1'b1;
                  rx_state_nx = RX_IDLE;
               end else begin
                  rx_ferr_set = 1'b1;
                  rx_state_nx = RX_WAIT_HIGH;
               end
            end else begin
               rx_cnt_nx = rx_cnt + 1'b1;
            end
         end
         RX_WAIT_HIGH: begin
            // A broken frame leaves the line low; wait for idle before
            // looking for the next start bit.
            if (rx_sync) begin
               rx_state_nx = RX_IDLE;
            end
         end
         default: begin
            rx_state_nx = RX_IDLE;
            rx_cnt_nx   = '0;
            rx_idx_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta      <= 1'b1;
         rx_sync      <= 1'b1;
         rx_prev      <= 1'b1;
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_idx       <= '0;
         rx_shift     <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_meta  <= uart_rx;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_state <= rx_state_nx;
         rx_cnt   <= rx_cnt_nx;
         rx_idx   <= rx_idx_nx;
         rx_shift <= rx_shift_nx;
         if (rx_done) begin
            rx_data <= rx_shift;
         end
         // Flag sets take priority over a W1C landing on the same edge.
         rx_valid     <= (rx_valid & ~clr_valid) | rx_done;
         rx_overrun   <= (rx_overrun & ~clr_overrun) | (rx_done & rx_valid);
         rx_frame_err <= (rx_frame_err & ~clr_frame_err) | rx_ferr_set;
      end
   end

   // ------------------------------------------------------------------
   // Read mux (no side effects)
   // ------------------------------------------------------------------
   logic [LENGTH-1:0] rd_data;

   always_comb begin
      rd_data = '0;
      case (sel)
         REG_TX_DATA:   rd_data[7:0] = tx_byte;
         REG_TX_STATUS: rd_data[1:0] = {tx_drop, tx_busy};
         REG_RX_DATA:   rd_data[7:0] = rx_data;
         REG_RX_STATUS: rd_data[2:0] = {rx_frame_err, rx_overrun, rx_valid};
         default:       rd_data      = '0;
      endcase
   end

   assign HRDATA_UART = hit ? rd_data : '0;

   logic unused_bits;
   assign unused_bits = ^{HADDR[1:0], HWDATA[LENGTH-1:8]};

endmodule

// File: doc/uart_mmio_responder.md
Name: uart_mmio_responder

Overview:
Memory-mapped UART peripheral that responds to the multicycle RISC-V core's data bus (address, write data, MemWrite). It decodes a 16-byte window at BASE_ADDR and supplies read data for the top-level HRDATA mux. Internally it runs an 8N1 transmitter and an 8N1 receiver with status flags. Reads have no side effects; all flag clearing is by explicit write.

Parameters:
LENGTH, 32, bus data/address width
BASE_ADDR, 32'h1001_0000, peripheral window base (16-byte aligned)
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
HADDR  input  LENGTH  byte address from core address mux
HWDATA  input  LENGTH  write data (core RD2 register)
MemWrite  input  1  core write enable
HRDATA_UART  output  LENGTH  read data; 0 when hit=0
hit  output  1  HADDR inside the window (top-level HRDATA select)
uart_tx  output  1  serial out, idle high
uart_rx  input  1  serial in, asynchronous to clock

Behaviour:
- Single clock; reset asynchronous, active-low. While reset=0: uart_tx=1, both FSMs IDLE, all flags/data/counters 0, so HRDATA_UART reads 0.
- hit = (HADDR[31:4] == BASE_ADDR[31:4]), combinational. Register select = HADDR[3:2]; HADDR[1:0] ignored.
- Map: 0x0 TX_DATA (W: [7:0] byte; R: last accepted byte); 0x4 TX_STATUS (R: bit0 busy, bit1 drop; W1C bit1); 0x8 RX_DATA (R: [7:0], upper bits 0; W ignored); 0xC RX_STATUS (R: bit0 valid, bit1 overrun, bit2 frame_err; W1C bits 2:0).
- Reads are combinational from HADDR with zero latency, because the core registers the bus every cycle.
- Write strobe: wr = MemWrite & hit & ~wr_q, where wr_q holds last cycle's (MemWrite & hit). A multi-cycle MemWrite counts as one write.
- TX FSM states: IDLE, START, DATA, STOP. Bit counter 0..CLKS_PER_BIT-1 and bit index 0..7.
  - A TX_DATA write in IDLE latches the byte. The next cycle enters START with busy=1.
  - START drives tx=0 for CLKS_PER_BIT cycles. DATA drives bits LSB first, each for CLKS_PER_BIT cycles. STOP drives tx=1 for CLKS_PER_BIT cycles, then returns to IDLE and busy=0.
  - Frame occupies exactly 10*CLKS_PER_BIT cycles.
  - A TX_DATA write while not IDLE (including the last STOP cycle) is dropped: drop=1, and the frame in flight is unaffected.
  - uart_tx is registered.
- RX path: 2-flop synchronizer on uart_rx, reset to 1.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE→START on synchronized falling edge.
  - START samples at CLKS_PER_BIT/2. If the line is 1, it is a glitch: return to IDLE with no flag. If 0, go to DATA.
  - DATA samples 8 bits at full-bit intervals, LSB first, into a shift register.
  - STOP samples after one more bit period.
    - Line 1: RX_DATA := shift register, valid := 1. If valid was already 1, overrun := 1 and the data is overwritten. Go to IDLE.
    - Line 0: frame_err := 1, RX_DATA unchanged, go to WAIT_HIGH.
  - WAIT_HIGH returns to IDLE when the synchronized line is 1.
- Simultaneous events: if a W1C hits the same cycle a flag is set, the set wins.
- Reset mid-frame aborts immediately (uart_tx=1); no partial frame resumes after reset release.

Test Plan:
- Reset: hold reset=0 with uart_rx=1, then release → uart_tx=1, and reads at 0x0/0x4/0x8/0xC return 0; HADDR=0x1000_0000 gives hit=0 and HRDATA_UART=0.
- TX, CLKS_PER_BIT=4: write 0x55 to BASE+0 → uart_tx, per 4-cycle bit, is 0,1,0,1,0,1,0,1,0,1. TX_STATUS reads 1 during the frame and 0 after 40 cycles. MemWrite held 3 cycles → single frame, drop=0.
- Drop: write 0xAA during the 0x55 frame → frame stays 0x55 and TX_STATUS=0x3 mid-frame. After the frame TX_STATUS=0x2. Writing 0x2 to BASE+4 → 0x0.
- RX, CLKS_PER_BIT=8: drive frame 0xA3 → RX_DATA=0xA3, RX_STATUS=0x1. Then drive frame 0x5C with no clear → RX_DATA=0x5C, RX_STATUS=0x3. Writing 0x3 to BASE+C → 0x0.
- Frame error: frame 0x3C with stop bit 0 → RX_STATUS bit2=1 and RX_DATA unchanged. Line held low for 30 more cycles gives no new frame; line high then frame 0x11 → RX_DATA=0x11.
- Glitch/collision: uart_rx low for 2 cycles → no flags set. A W1C of valid in the same cycle a new byte completes → valid remains 1. Reset=0 mid-TX → uart_tx=1 within the same cycle.
